// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed 16-bit word image over 8N1 UART and
// writes it to instruction RAM port B while holding the CPU. Optional: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              frame_err,
  output logic [15:0]       words_loaded
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic              csum_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [3:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CSUM_HI, S_CSUM_LO, S_ERROR
`endif
  } state_t;

  // ---------------- RX front end ----------------
  rx_state_t        rx_state;
  logic [1:0]       sync_ff;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_valid;
  logic             stop_err;

  assign rx_s = sync_ff[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff    <= 2'b11;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples
      // pre-edge values; blocking here would make ordering inside the block matter.
      sync_ff    <= {sync_ff[0], rx};
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt      <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              // Bad stop bit: drop the byte and wait out the low line before re-arming.
              stop_err <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: if (rx_s) rx_state <= RX_IDLE;
        default:      rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Loader FSM ----------------
  state_t     state;
  logic [15:0] len;
  logic [7:0]  hi_byte;
  logic        rearm_ok;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] csum_acc;
  assign rearm_ok = rearm && (state == S_DONE || state == S_ERROR);
`else
  assign rearm_ok = rearm && (state == S_DONE);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_LEN_HI;
      len          <= '0;
      hi_byte      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE;
      mem_data     <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      frame_err    <= 1'b0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_acc     <= '0;
      csum_err     <= 1'b0;
`endif
    end else begin
      // NOTE: mem_we defaults low each cycle so the write strobe is a single-cycle pulse.
      mem_we <= 1'b0;
      if (stop_err) frame_err <= 1'b1;
      if (rearm_ok) begin
        state        <= S_LEN_HI;
        mem_addr     <= BASE;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        frame_err    <= 1'b0;
        words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_acc     <= '0;
        csum_err     <= 1'b0;
`endif
      end else begin
        case (state)
          S_LEN_HI: if (byte_valid) begin
            len[15:8] <= shreg;
            state     <= S_LEN_LO;
          end
          S_LEN_LO: if (byte_valid) begin
            len[7:0] <= shreg;
            if ({len[15:8], shreg} == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= S_CSUM_HI;
`else
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
          S_DATA_HI: if (byte_valid) begin
            hi_byte <= shreg;
            state   <= S_DATA_LO;
          end
          S_DATA_LO: if (byte_valid) begin
            mem_data <= {hi_byte, shreg};
            mem_we   <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_acc <= csum_acc ^ {hi_byte, shreg};
`endif
            state    <= S_WRITE;
          end
          S_WRITE: begin
            // Address advances after the strobe so addr/data stay stable during it.
            words_loaded <= words_loaded + 16'd1;
            mem_addr     <= mem_addr + 1'b1;
            if (words_loaded + 16'd1 == len) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= S_CSUM_HI;
`else
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CSUM_HI: if (byte_valid) begin
            hi_byte <= shreg;
            state   <= S_CSUM_LO;
          end
          S_CSUM_LO: if (byte_valid) begin
            if ({hi_byte, shreg} == csum_acc) begin
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= S_ERROR;
              csum_err <= 1'b1;
            end
          end
          S_ERROR: ;
`endif
          S_DONE:  ;
          default: state <= S_LEN_HI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: UART byte driver, image/checksum model and
// expected-write list derived from base address + word index.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        rx_w = 1'b1;
  logic        rearm = 1'b0;

  logic        mem_we, cpu_hold, done, frame_err;
  logic [15:0] mem_addr, mem_data, words_loaded;
  logic        w_mem_we, w_cpu_hold, w_done, w_frame_err;
  logic [15:0] w_mem_addr, w_mem_data, w_words_loaded;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic        csum_err, w_csum_err;
`endif

  prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rearm(rearm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .done(done), .frame_err(frame_err), .words_loaded(words_loaded)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .csum_err(csum_err)
`endif
  );

  prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(16), .BASE_ADDR(16'hFFFF)) dut_w (
    .clk(clk), .reset(reset), .rx(rx_w), .rearm(rearm),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
    .cpu_hold(w_cpu_hold), .done(w_done), .frame_err(w_frame_err), .words_loaded(w_words_loaded)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .csum_err(w_csum_err)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] obs_q[$];
  logic [31:0] obs_w_q[$];
  logic [15:0] exp_words[$];
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    if (mem_we)   obs_q.push_back({mem_addr, mem_data});
    if (w_mem_we) obs_w_q.push_back({w_mem_addr, w_mem_data});
  end

  // Model: the byte stream for an image is LEN (big-endian), each word hi/lo, then the XOR checksum.
  function automatic void build_stream();
    logic [15:0] x;
    logic [15:0] n;
    x = 16'h0000;
    n = 16'(exp_words.size());
    tx_q.delete();
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    foreach (exp_words[i]) begin
      tx_q.push_back(exp_words[i][15:8]);
      tx_q.push_back(exp_words[i][7:0]);
      x = x ^ exp_words[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    tx_q.push_back(x[15:8]);
    tx_q.push_back(x[7:0]);
`endif
  endfunction

  function automatic void random_words(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_w = v;
    else     rx   = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
    @(negedge clk);
    drive(sel, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (CPB) @(negedge clk);
    end
    drive(sel, stop);
    repeat (CPB) @(negedge clk);
    drive(sel, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_range(input bit sel, input int from, input int to);
    for (int i = from; i < to; i++) send_byte(sel, tx_q[i], 1'b1);
  endtask

  task automatic wait_done(input bit sel, input string name);
    int n;
    n = 0;
    while (((sel ? w_done : done) !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ((sel ? w_done : done) !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: done=%b required 1", name, sel ? w_done : done);
    end
  endtask

  task automatic do_rearm();
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (mem_we !== 1'b0 || mem_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_we_data: we=%b data=%h required 0/0000", mem_we, mem_data);
    end
    tests_run++;
    if (mem_addr !== 16'h0000 || w_mem_addr !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL reset_addr: %h/%h required 0000/ffff", mem_addr, w_mem_addr);
    end
    tests_run++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || frame_err !== 1'b0 || words_loaded !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_status: hold=%b done=%b ferr=%b words=%0d required 1/0/0/0",
               cpu_hold, done, frame_err, words_loaded);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string name, input logic [15:0] base);
    // Expected write i lands at (base + i) mod 2^16 with word i of the image.
    tests_run++;
    if (obs_q.size() != exp_words.size()) begin
      tests_failed++;
      $display("FAIL %s_count: %0d writes required %0d", name, obs_q.size(), exp_words.size());
    end
    for (int i = 0; i < exp_words.size(); i++) begin
      logic [31:0] act;
      logic [15:0] a;
      a = base + 16'(i);
      act = (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx;
      tests_run++;
      if (act !== {a, exp_words[i]}) begin
        tests_failed++;
        $display("FAIL %s_write%0d: %h required %h", name, i, act, {a, exp_words[i]});
      end
    end
  endtask

  task automatic test_basic();
    exp_words = '{16'h1234, 16'hABCD};
    build_stream();
    obs_q.delete();
    send_range(0, 0, tx_q.size() - 1);
    tests_run++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_hold_early: hold=%b done=%b required 1/0", cpu_hold, done);
    end
    send_range(0, tx_q.size() - 1, tx_q.size());
    wait_done(0, "basic");
    check_writes("basic", 16'h0000);
    tests_run++;
    if (words_loaded !== 16'd2 || cpu_hold !== 1'b0 || mem_addr !== 16'd2) begin
      tests_failed++;
      $display("FAIL basic_final: words=%0d hold=%b addr=%h required 2/0/0002",
               words_loaded, cpu_hold, mem_addr);
    end
  endtask

  task automatic test_zero_len();
    do_rearm();
    tests_run++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0 || mem_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL rearm_state: hold=%b done=%b words=%0d addr=%h required 1/0/0/0000",
               cpu_hold, done, words_loaded, mem_addr);
    end
    exp_words.delete();
    build_stream();
    obs_q.delete();
    send_range(0, 0, tx_q.size());
    wait_done(0, "zero_len");
    send_byte(0, 8'h77, 1'b1);
    tests_run++;
    if (obs_q.size() != 0 || cpu_hold !== 1'b0 || words_loaded !== 16'd0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_len: writes=%0d hold=%b words=%0d done=%b required 0/0/0/1",
               obs_q.size(), cpu_hold, words_loaded, done);
    end
  endtask

  task automatic test_frame_err();
    do_rearm();
    random_words(3);
    build_stream();
    obs_q.delete();
    send_range(0, 0, 4);
    send_byte(0, tx_q[4], 1'b0);
    repeat (5) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b1 || words_loaded !== 16'd1 || obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL frame_err_set: ferr=%b words=%0d writes=%0d required 1/1/1",
               frame_err, words_loaded, obs_q.size());
    end
    send_range(0, 4, tx_q.size());
    wait_done(0, "frame_err");
    check_writes("frame_err", 16'h0000);
    tests_run++;
    if (frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_err_sticky: ferr=%b required 1", frame_err);
    end
    do_rearm();
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_clear: ferr=%b required 0", frame_err);
    end
  endtask

  task automatic test_glitch();
    random_words(1);
    build_stream();
    obs_q.delete();
    send_range(0, 0, 1);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b0 || obs_q.size() != 0 || cpu_hold !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_idle: ferr=%b writes=%0d hold=%b required 0/0/1",
               frame_err, obs_q.size(), cpu_hold);
    end
    send_range(0, 1, tx_q.size());
    wait_done(0, "glitch");
    check_writes("glitch", 16'h0000);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 5);
      do_rearm();
      random_words(n);
      build_stream();
      obs_q.delete();
      send_range(0, 0, 2);
      do_rearm();
      send_range(0, 2, tx_q.size());
      wait_done(0, "random");
      check_writes("random", 16'h0000);
      tests_run++;
      if (words_loaded !== 16'(n) || mem_addr !== 16'(n)) begin
        tests_failed++;
        $display("FAIL random_count: words=%0d addr=%h required %0d", words_loaded, mem_addr, n);
      end
    end
  endtask

  task automatic test_wrap();
    random_words(2);
    build_stream();
    obs_w_q.delete();
    send_range(1, 0, tx_q.size());
    wait_done(1, "wrap");
    tests_run++;
    if (obs_w_q.size() != 2) begin
      tests_failed++;
      $display("FAIL wrap_count: %0d writes required 2", obs_w_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      logic [31:0] act;
      logic [15:0] a;
      a = 16'hFFFF + 16'(i);
      act = (i < obs_w_q.size()) ? obs_w_q[i] : 32'hxxxxxxxx;
      tests_run++;
      if (act !== {a, exp_words[i]}) begin
        tests_failed++;
        $display("FAIL wrap_write%0d: %h required %h", i, act, {a, exp_words[i]});
      end
    end
    tests_run++;
    if (w_mem_addr !== 16'h0001) begin
      tests_failed++;
      $display("FAIL wrap_addr: %h required 0001", w_mem_addr);
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int n;
    do_rearm();
    tx_q = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h55, 8'hAA};
    send_range(0, 0, tx_q.size());
    wait_done(0, "csum_ok");
    tests_run++;
    if (csum_err !== 1'b0 || cpu_hold !== 1'b0) begin
      tests_failed++;
      $display("FAIL csum_ok: err=%b hold=%b required 0/0", csum_err, cpu_hold);
    end
    do_rearm();
    tx_q = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h00, 8'h00};
    send_range(0, 0, tx_q.size());
    n = 0;
    while (csum_err !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (csum_err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL csum_bad: err=%b hold=%b done=%b required 1/1/0", csum_err, cpu_hold, done);
    end
    do_rearm();
    tests_run++;
    if (csum_err !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL csum_rearm: err=%b hold=%b done=%b required 0/1/0", csum_err, cpu_hold, done);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    do_rearm();
    random_words(2);
    build_stream();
    send_range(0, 0, 4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (mem_addr !== 16'h0 || words_loaded !== 16'd0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: addr=%h words=%0d hold=%b done=%b required 0000/0/1/0",
               mem_addr, words_loaded, cpu_hold, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_frame_err();
    test_glitch();
    test_random();
    test_wrap();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader: receives a program image over a UART line and writes it as 16-bit words into the instruction memory, through the write side of the dual-port RAM (port B).
- Holds the CPU (FSM, PC) in hold until the image is fully written, then releases it.
- Sits between the board RX pin and the RAM port B mux; the CPU fetch path reads what this block writes.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division, must be >= 4.
- ADDR_W, 16, RAM address width.
- BASE_ADDR, 0, address of the first loaded word.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial in; idle high; 8N1 framing, LSB first.
- rearm  input  1  single-cycle pulse; from DONE or ERROR, restarts loading.
- mem_we  output  1  one-cycle write strobe to RAM port B.
- mem_addr  output  ADDR_W  write address.
- mem_data  output  16  write data.
- cpu_hold  output  1  high while loading; CPU must not advance.
- done  output  1  high in DONE.
- frame_err  output  1  sticky; a stop bit was sampled low.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_data=0, cpu_hold=1, done=0, frame_err=0, words_loaded=0, FSM in LEN_HI, RX idle.
- RX front end:
  - rx passes through a 2-FF synchronizer.
  - Start is detected on a synchronized high-to-low transition.
  - Line is re-sampled at CLKS_PER_BIT/2; if high there, it was a glitch and RX returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that point; the stop bit is sampled likewise.
  - Stop low: byte discarded, frame_err set, RX waits for the line to be high before re-arming. The FSM does not advance.
  - A valid byte produces a one-cycle byte_valid pulse 1 cycle after the stop-bit sample.
- Protocol (big-endian bytes):
  - Two-byte LEN, then LEN words, each sent high byte then low byte.
- FSM states and transitions:
  - LEN_HI -> LEN_LO on byte.
  - LEN_LO on byte: LEN==0 goes to DONE, else DATA_HI.
  - DATA_HI -> DATA_LO on byte.
  - DATA_LO -> WRITE on byte.
  - WRITE, exactly 1 cycle: mem_we=1 with mem_addr/mem_data stable, and words_loaded increments. Then go to DONE if words_loaded+1==LEN, else DATA_HI.
  - DONE: cpu_hold=0, done=1; incoming bytes ignored.
- Addressing:
  - mem_addr increments by 1 the cycle after each write.
  - Wraps modulo 2^ADDR_W; no error on wrap.
- Write timing: mem_data/mem_addr are valid in the same cycle as mem_we. Write latency is 1 cycle from the low-byte byte_valid.
- rearm:
  - Honoured only in DONE or ERROR; ignored in other states.
  - Action: cpu_hold=1, done=0, frame_err=0, words_loaded=0, mem_addr=BASE_ADDR, next state LEN_HI, next cycle.
- Reset mid-load: immediate abort to reset values. RAM contents already written are left as is.
- rearm and byte_valid in the same cycle in DONE: rearm wins and the byte is dropped.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the FSM enters CSUM_HI, then CSUM_LO, and receives a 16-bit word.
  - That word is compared against the XOR of all LEN data words; LEN==0 compares against 0x0000.
  - Match: DONE.
  - Mismatch: ERROR, with cpu_hold=1, done=0, and output csum_err=1, which exists only under this macro.
- Undefined: no checksum states, no ERROR entry, no csum_err port. ERROR is reachable only with the macro defined.

Test Plan (CLK_HZ=1000000, BAUD=100000, so 10 clocks/bit):
- Release reset, send 00 02 12 34 AB CD -> writes 0x1234@0 then 0xABCD@1, each one mem_we pulse; words_loaded=2; cpu_hold falls and done rises after the second write.
- Send 00 00 -> DONE with zero mem_we pulses, cpu_hold=0.
- Byte with stop bit held low mid-image -> frame_err=1, byte dropped, FSM state unchanged; the resent byte completes the load normally.
- 3-clock low glitch on idle rx -> no byte_valid, state unchanged.
- BASE_ADDR=0xFFFF, LEN=2 -> writes land at 0xFFFF then 0x0000.
- Checksum macro defined: 00 01 55 AA 55 AA -> DONE. Repeat after rearm with checksum 00 00 -> ERROR, csum_err=1, cpu_hold=1.
